// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM-load path: FIFO word, unpacker state,
// status-word bit positions and the byte-lane select helper.
// No ports; imported by rom_word_fifo and rom_byte_unpacker.
package rom_loader_pkg;

  // The FIFO word type is fixed at package level, so the top's ROM_ADDR_WIDTH
  // must equal ROM_AW.
  localparam int ROM_AW  = 20;
  localparam int WORD_AW = ROM_AW - 2;

  typedef struct packed {
    logic [WORD_AW-1:0] word_addr;
    logic [31:0]        data;
  } rom_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } unpack_state_e;

  // Status word returned on bridge reads.
  localparam int ST_BUSY_BIT = 31;
  localparam int ST_OVF_BIT  = 30;
  localparam int ST_RNG_BIT  = 29;
  localparam int ST_CSUM_LSB = 21;

  // Byte idx 0 is the lowest ROM address. Big-endian puts it in bits [31:24].
  function automatic logic [7:0] select_byte(input logic [31:0] w,
                                             input logic [1:0]  idx,
                                             input bit          big_endian);
    logic [1:0] lane;
    lane = big_endian ? ~idx : idx;
    return w[8*lane +: 8];
  endfunction

endpackage

// File: rtl/rom_word_fifo.sv
// Synchronous single-clock FIFO of rom_word_t; read data is the registered
// head entry, valid the cycle after the push that wrote it.
// Ports: clk, reset (sync, active-high), push/push_data, pop/pop_data, full, empty.
module rom_word_fifo
  import rom_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  rom_word_t push_data,
  input  logic      pop,
  output rom_word_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);

  rom_word_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/rom_byte_unpacker.sv
// Buffers 32-bit bridge writes to the ROM window and replays each as four byte
// writes (valid/ready) to the core ROM-load port, with load status and sticky errors.
// Ports: bridge write/read side, rom_wr/rom_addr/rom_data/rom_ready, busy,
// bytes_loaded, overflow, range_err, checksum. Optional macro: ROM_CHECKSUM_EN.
module rom_byte_unpacker
  import rom_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int          ROM_ADDR_WIDTH = ROM_AW,
  parameter int          FIFO_DEPTH     = 4,
  parameter bit          BIG_ENDIAN     = 1'b1
) (
  input  logic                      clk_74a,
  input  logic                      reset,
  input  logic                      bridge_wr,
  input  logic [31:0]               bridge_addr,
  input  logic [31:0]               bridge_wr_data,
  input  logic                      bridge_rd,
  output logic [31:0]               bridge_rd_data,
  output logic                      rom_wr,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  output logic [7:0]                rom_data,
  input  logic                      rom_ready,
  output logic                      busy,
  output logic [ROM_ADDR_WIDTH:0]   bytes_loaded,
  output logic                      overflow,
  output logic                      range_err,
  output logic [15:0]               checksum
);

  localparam logic [32:0]             WIN_SIZE = 33'd1 << ROM_ADDR_WIDTH;
  localparam logic [ROM_ADDR_WIDTH:0] CNT_MAX  = (ROM_ADDR_WIDTH+1)'(1) << ROM_ADDR_WIDTH;

  // Window check and push.
  logic [31:0] off;
  logic        in_range;
  logic        wr_ok;
  rom_word_t   push_word;
  rom_word_t   head_word;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;

  assign off      = bridge_addr - ADDR_BASE;
  assign in_range = (bridge_addr >= ADDR_BASE) && ({1'b0, off} < WIN_SIZE);
  assign wr_ok    = bridge_wr && in_range;

  assign push_word.word_addr = off[ROM_ADDR_WIDTH-1:2];
  assign push_word.data      = bridge_wr_data;

  rom_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_74a),
    .reset     (reset),
    .push      (wr_ok),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Unpacker FSM.
  unpack_state_e state;
  unpack_state_e state_next;
  logic [1:0]    idx;
  logic [1:0]    idx_next;
  rom_word_t     word;
  logic          accept;

  assign accept = rom_wr && rom_ready;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          idx_next   = 2'd0;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (rom_ready) begin
          if (idx != 2'd3) begin
            idx_next = idx + 2'd1;
          end else if (!fifo_empty) begin
            // Back-to-back words: reload without an idle cycle.
            pop      = 1'b1;
            idx_next = 2'd0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 2'd0;
      word  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (pop) word <= head_word;
    end
  end

  assign rom_wr   = (state == EMIT);
  assign rom_addr = {word.word_addr, idx};
  assign rom_data = select_byte(word.data, idx, BIG_ENDIAN);
  assign busy     = !fifo_empty || rom_wr;

  // Progress counter and sticky error flags.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      bytes_loaded <= '0;
      overflow     <= 1'b0;
      range_err    <= 1'b0;
    end else begin
      if (accept && bytes_loaded != CNT_MAX) bytes_loaded <= bytes_loaded + 1'b1;
      // Dropped only if no pop frees a slot this cycle.
      if (wr_ok && fifo_full && !pop) overflow <= 1'b1;
      if (bridge_wr && !in_range)     range_err <= 1'b1;
    end
  end

`ifdef ROM_CHECKSUM_EN
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + 16'(rom_data);
    end
  end
`else
  assign checksum = '0;
`endif

  // Status readback, one-cycle registered.
  logic [31:0] status;

  always_comb begin
    status                      = '0;
    status[ST_BUSY_BIT]         = busy;
    status[ST_OVF_BIT]          = overflow;
    status[ST_RNG_BIT]          = range_err;
    status[ST_CSUM_LSB +: 8]    = checksum[7:0];
    status[ROM_ADDR_WIDTH:0]    = bytes_loaded;
  end

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      bridge_rd_data <= '0;
    end else if (bridge_rd) begin
      bridge_rd_data <= status;
    end
  end

endmodule

// File: tb/tb_rom_byte_unpacker.sv
module tb_rom_byte_unpacker;

  logic        clk_74a = 1'b0;
  logic        reset = 1'b1;
  logic        bridge_wr = 1'b0;
  logic [31:0] bridge_addr = '0;
  logic [31:0] bridge_wr_data = '0;
  logic        bridge_rd = 1'b0;
  logic [31:0] bridge_rd_data;
  logic        rom_wr;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ready = 1'b0;
  logic        busy;
  logic [20:0] bytes_loaded;
  logic        overflow;
  logic        range_err;
  logic [15:0] checksum;

  rom_byte_unpacker dut (
    .clk_74a        (clk_74a),
    .reset          (reset),
    .bridge_wr      (bridge_wr),
    .bridge_addr    (bridge_addr),
    .bridge_wr_data (bridge_wr_data),
    .bridge_rd      (bridge_rd),
    .bridge_rd_data (bridge_rd_data),
    .rom_wr         (rom_wr),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_ready      (rom_ready),
    .busy           (busy),
    .bytes_loaded   (bytes_loaded),
    .overflow       (overflow),
    .range_err      (range_err),
    .checksum       (checksum)
  );

  always #5 clk_74a = ~clk_74a;

  int unsigned cyc = 0;
  always @(posedge clk_74a) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned cyc;
    logic [19:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t         exp_q[$];   // bytes still owed to the core, in order
  ev_t         log_q[$];   // bytes the core actually accepted
  logic [20:0] m_bytes = '0;
  logic        m_ovf = 1'b0;
  logic        m_rng = 1'b0;
  logic [15:0] m_cs = '0;
  logic        drv_drop = 1'b0;  // stimulus marks a write it expects to overflow
  logic        armed = 1'b0;
  logic        stall_prev = 1'b0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_exp = '0;

  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] WIN  = 32'h0010_0000;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[31] = (exp_q.size() != 0);
    s[30] = m_ovf;
    s[29] = m_rng;
`ifdef ROM_CHECKSUM_EN
    s[28:21] = m_cs[7:0];
`endif
    s[20:0] = m_bytes;
    return s;
  endfunction

  always @(negedge clk_74a) begin
    ev_t e;
    if (armed) begin
      chk("busy", busy, (exp_q.size() != 0));
      chk("bytes_loaded", bytes_loaded, m_bytes);
      chk("overflow", overflow, m_ovf);
      chk("range_err", range_err, m_rng);
      chk("checksum", checksum, m_cs);
      if (stall_prev) chk("rom_wr_held", rom_wr, 1'b1);
      if (rom_wr) begin
        chk("rom_wr_has_work", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          chk("rom_addr", rom_addr, exp_q[0].addr);
          chk("rom_data", rom_data, exp_q[0].data);
        end
      end
      if (rd_pend) chk("bridge_rd_data", bridge_rd_data, rd_exp);
    end
    // Advance the model to what the coming clock edge must produce.
    if (reset) begin
      exp_q.delete();
      m_bytes = '0; m_ovf = 1'b0; m_rng = 1'b0; m_cs = '0;
      stall_prev = 1'b0; rd_pend = 1'b0; armed = 1'b1;
    end else if (armed) begin
      rd_pend = bridge_rd;
      if (bridge_rd) rd_exp = exp_status();
      stall_prev = rom_wr && !rom_ready;
      if (rom_wr && rom_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (m_bytes != 21'h10_0000) m_bytes = m_bytes + 1'b1;
`ifdef ROM_CHECKSUM_EN
        m_cs = m_cs + 16'(e.data);
`endif
        e.cyc = cyc;
        log_q.push_back(e);
      end
      if (bridge_wr) begin
        if (bridge_addr >= BASE && (bridge_addr - BASE) < WIN) begin
          if (drv_drop) m_ovf = 1'b1;
          else begin
            for (int i = 0; i < 4; i++) begin
              e.cyc  = 0;
              e.addr = 20'(((bridge_addr - BASE) & ~32'd3) + 32'(i));
              e.data = 8'((bridge_wr_data >> (8 * (3 - i))) & 32'hFF);
              exp_q.push_back(e);
            end
          end
        end else begin
          m_rng = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_74a);
      #1;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic drop, output int unsigned n);
    bridge_wr = 1'b1; bridge_addr = a; bridge_wr_data = d; drv_drop = drop;
    n = cyc;
    tick(1);
    bridge_wr = 1'b0; drv_drop = 1'b0;
  endtask

  task automatic do_read(input string nm, input logic [31:0] exp);
    bridge_rd = 1'b1;
    tick(1);
    bridge_rd = 1'b0;
    @(negedge clk_74a);
    chk(nm, bridge_rd_data, exp);
    @(posedge clk_74a);
    #1;
  endtask

  task automatic chk_ev(input string nm, input int idx, input int unsigned c,
                        input logic [19:0] a, input logic [7:0] d);
    chk({nm, "_present"}, (idx < log_q.size()), 1'b1);
    if (idx < log_q.size()) begin
      chk({nm, "_cyc"}, log_q[idx].cyc, c);
      chk({nm, "_addr"}, log_q[idx].addr, a);
      chk({nm, "_data"}, log_q[idx].data, d);
    end
  endtask

  localparam logic [31:0] CS_BITS =
`ifdef ROM_CHECKSUM_EN
    32'h1A80_0000;   // checksum 0x05D4 -> low byte D4 in bits 28:21
`else
    32'h0;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned n0;
    int b;
    logic [5:0] pat;

    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    // Reset state.
    @(negedge clk_74a);
    chk("rst_rom_wr", rom_wr, 1'b0);
    chk("rst_rom_addr", rom_addr, 20'h0);
    chk("rst_rom_data", rom_data, 8'h0);
    chk("rst_rd_data", bridge_rd_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bytes", bytes_loaded, 21'h0);
    chk("rst_flags", {overflow, range_err}, 2'b00);
    chk("rst_checksum", checksum, 16'h0);
    @(posedge clk_74a);
    #1;

    // Single word, full-speed.
    rom_ready = 1'b1;
    do_write(32'h10, 32'hA1B2_C3D4, 1'b0, n);
    tick(5);
    @(negedge clk_74a);
    chk("t1_count", log_q.size(), 4);
    chk_ev("t1_b0", 0, n + 2, 20'h10, 8'hA1);
    chk_ev("t1_b1", 1, n + 3, 20'h11, 8'hB2);
    chk_ev("t1_b2", 2, n + 4, 20'h12, 8'hC3);
    chk_ev("t1_b3", 3, n + 5, 20'h13, 8'hD4);
    chk("t1_bytes", bytes_loaded, 21'd4);
    chk("t1_busy_low", busy, 1'b0);
    @(posedge clk_74a);
    #1;

    // Backpressure: ready 1,0,0,1,1,1 from the first byte.
    pat = 6'b111001;  // bit i is cycle i
    do_write(32'h10, 32'hA1B2_C3D4, 1'b0, n);
    tick(1);
    for (int i = 0; i < 6; i++) begin
      rom_ready = pat[i];
      tick(1);
    end
    rom_ready = 1'b1;
    @(negedge clk_74a);
    chk("t2_count", log_q.size(), 8);
    chk_ev("t2_b0", 4, n + 2, 20'h10, 8'hA1);
    chk_ev("t2_b1", 5, n + 5, 20'h11, 8'hB2);
    chk_ev("t2_b2", 6, n + 6, 20'h12, 8'hC3);
    chk_ev("t2_b3", 7, n + 7, 20'h13, 8'hD4);
    @(posedge clk_74a);
    #1;

    // Out-of-window write.
    b = log_q.size();
    do_write(32'h0010_0000, 32'hDEAD_BEEF, 1'b0, n);
    tick(4);
    @(negedge clk_74a);
    chk("t3_range_err", range_err, 1'b1);
    chk("t3_no_rom_wr", log_q.size(), b);
    chk("t3_busy", busy, 1'b0);
    @(posedge clk_74a);
    #1;
    do_read("t3_status", 32'h2000_0008 | CS_BITS);

    // Overflow: stalled core, six back-to-back writes.
    rom_ready = 1'b0;
    b = log_q.size();
    for (int i = 0; i < 6; i++)
      do_write(32'h100 + 32'(4 * i), 32'h1020_3040 + 32'(i) * 32'h0101_0101, (i == 5), n);
    tick(2);
    @(negedge clk_74a);
    chk("t4_overflow", overflow, 1'b1);
    chk("t4_busy", busy, 1'b1);
    chk("t4_none_yet", log_q.size(), b);
    @(posedge clk_74a);
    #1;
    do_read("t4_status", 32'hE000_0008 | CS_BITS);
    rom_ready = 1'b1;
    tick(25);
    @(negedge clk_74a);
    chk("t4_count", log_q.size() - b, 20);
    if (log_q.size() >= b + 20) begin
      chk("t4_first_addr", log_q[b].addr, 20'h100);
      chk("t4_first_data", log_q[b].data, 8'h10);
      chk("t4_last_addr", log_q[b + 19].addr, 20'h113);
      chk("t4_last_data", log_q[b + 19].data, 8'h44);
      chk("t4_no_bubble", log_q[b + 19].cyc - log_q[b].cyc, 19);
    end
    chk("t4_bytes", bytes_loaded, 21'd28);
    chk("t4_ovf_sticky", overflow, 1'b1);
    @(posedge clk_74a);
    #1;

    // Reset while byte idx 1 is on the port.
    do_write(32'h20, 32'h5566_7788, 1'b0, n0);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk_74a);
    chk("t5_rom_wr", rom_wr, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_bytes", bytes_loaded, 21'd0);
    chk("t5_last_before_rst", log_q[log_q.size() - 1].addr, 20'h20);
    @(posedge clk_74a);
    #1;
    b = log_q.size();
    do_write(32'h0, 32'h1122_3344, 1'b0, n);
    tick(5);
    @(negedge clk_74a);
    chk("t5_count", log_q.size() - b, 4);
    chk_ev("t5_b0", b, n + 2, 20'h0, 8'h11);
    chk_ev("t5_b3", b + 3, n + 5, 20'h3, 8'h44);
    @(posedge clk_74a);
    #1;

    // Checksum over two all-ones words.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    do_write(32'h40, 32'hFFFF_FFFF, 1'b0, n);
    do_write(32'h44, 32'hFFFF_FFFF, 1'b0, n);
    tick(10);
    @(negedge clk_74a);
    chk("t6_bytes", bytes_loaded, 21'd8);
`ifdef ROM_CHECKSUM_EN
    chk("t6_checksum", checksum, 16'h07F8);
`else
    chk("t6_checksum", checksum, 16'h0000);
`endif
    @(posedge clk_74a);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_byte_unpacker.md
Name: rom_byte_unpacker

Overview:
- Consumes the ROM leaf of the bridge fan-out, the 0x00000000–0x00100000 window. Host writes arrive there as 32-bit big-endian words.
- Buffers each word in a small FIFO, then replays it as four sequential byte writes with a valid/ready handshake. The byte writes go to the core ROM-load port inside athena_top.
- Absorbs bridge bursts, because the bridge has no backpressure, and reports load progress and overflow.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of ROM byte 0 on the bridge.
- ROM_ADDR_WIDTH, 20, width of the byte address presented to the core.
- FIFO_DEPTH, 4, word entries buffered; power of two, at least 2.
- BIG_ENDIAN, 1, 1 means bridge_wr_data[31:24] is the lowest byte address; 0 means bits [7:0] are.

Ports:
- clk_74a  in  1  bridge/core load clock; only clock.
- reset  in  1  synchronous, active-high.
- bridge_wr  in  1  one-cycle write strobe from the ROM leaf.
- bridge_addr  in  32  bridge byte address; bits [1:0] ignored.
- bridge_wr_data  in  32  write word.
- bridge_rd  in  1  read strobe.
- bridge_rd_data  out  32  read data.
- rom_wr  out  1  byte valid to core.
- rom_addr  out  ROM_ADDR_WIDTH  byte address.
- rom_data  out  8  byte data.
- rom_ready  in  1  core accepts the byte when high with rom_wr.
- busy  out  1  FIFO non-empty or unpacker emitting.
- bytes_loaded  out  ROM_ADDR_WIDTH+1  count of accepted bytes, saturating.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.
- range_err  out  1  sticky: a write fell outside the window.
- checksum  out  16  see Optional Feature.

Behaviour:
- Reset values (cycle after reset is high):
  - rom_wr=0, rom_addr=0, rom_data=0, bridge_rd_data=0.
  - busy=0, bytes_loaded=0, overflow=0, range_err=0, checksum=0.
  - FIFO empty, unpacker state IDLE.
- Window check:
  - off = bridge_addr - ADDR_BASE.
  - In range when ADDR_BASE <= bridge_addr and off < 2^ROM_ADDR_WIDTH.
  - An out-of-range bridge_wr is dropped and sets range_err.
- Push:
  - An in-range bridge_wr pushes {off[ROM_ADDR_WIDTH-1:2], data}.
  - If the FIFO is full and no pop occurs that cycle, the write is dropped and overflow is set.
  - Full with a same-cycle pop: the push is accepted and the count is unchanged.
- Reads:
  - bridge_rd_data is registered with 1-cycle latency.
  - Any read returns {busy, overflow, range_err, 8'h0, bytes_loaded zero-extended to 21 bits}.
- Unpacker FSM:
  - IDLE: if the FIFO is non-empty, pop into a word register, set idx=0 and go to EMIT.
  - EMIT: rom_wr=1, rom_addr={word_addr, idx}, rom_data is selected byte idx per BIG_ENDIAN.
  - EMIT, rom_ready=1 and idx<3: idx increments.
  - EMIT, rom_ready=1 and idx=3: if the FIFO is non-empty, pop, set idx=0 and stay in EMIT with no bubble; else go to IDLE.
  - EMIT, rom_ready=0: rom_addr and rom_data are held stable and rom_wr stays high (AXI-style).
- Latency: bridge_wr in cycle N with FIFO empty and FSM in IDLE gives the first rom_wr in cycle N+2.
- Throughput: one byte per cycle when rom_ready=1.
- bytes_loaded increments on each rom_wr&&rom_ready and saturates at 2^ROM_ADDR_WIDTH.
- busy = FIFO non-empty OR state==EMIT.
- Reset mid-transfer: the FIFO is flushed and the partial word is discarded; rom_wr is 0 in the next cycle.

Optional Feature:
- Macro: ROM_CHECKSUM_EN.
- Defined: checksum is a 16-bit wrapping sum of every accepted rom_data byte, cleared on reset. Read data bits [28:21] carry checksum[7:0].
- Not defined: checksum is tied to 0, those read bits read 0, and no adder logic is built.

Decomposition:
- Shared package rom_loader_pkg:
  - rom_word_t struct {word_addr, data}.
  - unpack_state_e enum {IDLE, EMIT}.
  - Status-word bit-position constants.
- Sub-module: rom_word_fifo, a synchronous single-clock FIFO of rom_word_t.
  - Ports: push, pop, full, empty.
  - Push-when-full-with-pop allowed.
  - Data valid the cycle after push (registered).

Test Plan:
- Single word, BIG_ENDIAN=1, rom_ready=1:
  - Stimulus: bridge_wr addr 0x10, data 0xA1B2C3D4.
  - Required: bytes A1,B2,C3,D4 at rom_addr 0x10–0x13 in consecutive cycles, first at N+2; bytes_loaded=4; busy drops after the last byte.
- Backpressure:
  - Stimulus: same word, rom_ready toggles 1,0,0,1,1,1.
  - Required: byte B2 held stable through the 0-cycles; all 4 bytes delivered exactly once, in order.
- Overflow, FIFO_DEPTH=4:
  - Stimulus: rom_ready=0, 6 back-to-back writes.
  - Required: FIFO holds 4 words plus 1 in the unpacker; the 6th write sets overflow=1.
  - Then release rom_ready: exactly 20 bytes emitted.
- Range:
  - Stimulus: write to addr 0x00100000.
  - Required: dropped, range_err=1, no rom_wr.
  - A following read returns bit 29 set.
- Reset mid-EMIT:
  - Stimulus: reset during byte idx 1.
  - Required: rom_wr=0 in the next cycle, busy=0, bytes_loaded=0.
  - A following write at addr 0 starts at idx 0.
- ROM_CHECKSUM_EN defined:
  - Stimulus: write 0xFFFFFFFF twice.
  - Required: checksum=0x07F8.
  - Without the macro: checksum=0.
